// File: rtl/display_sequencer_pkg.sv
// Shared codes for the display sequencer: lower-display mode codes, FSM state codes
// and the mode-to-one-hot decode used for the registered mode outputs.
package display_sequencer_pkg;

    localparam logic [1:0] MODE_DAY = 2'd0;
    localparam logic [1:0] MODE_AVS = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_TIM = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Bit order of the result is {TIM, MAX, AVS, DAY}.
    function automatic logic [3:0] mode_onehot(input logic [1:0] mode);
        mode_onehot = 4'b0001 << mode;
    endfunction

endpackage

// File: rtl/display_sequencer_cycle_timer.sv
// Loadable down-counter with zero flag. Decrement saturates at zero; load wins over
// decrement. Used for both the refresh interval and the conversion timeout.
module cycle_timer #(
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/display_sequencer.sv
// Display conversion sequencer: owns the lower-display mode, issues periodic conversion
// starts to the dual-to-ASCII converter, waits for valid with a timeout, strobes update.
module display_sequencer
    import display_sequencer_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic mode_btn,
    input  logic force_refresh,
    input  logic conv_valid,
    output logic start,
    output logic AVS,
    output logic DAY,
    output logic MAX,
    output logic TIM,
    output logic busy,
    output logic update,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] REFRESH_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       pending_q, pending_d;
    logic       first_wait_q, first_wait_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;
    logic       update_q, update_d;
    logic       timeout_err_q, timeout_err_d;
    logic [3:0] onehot_q, onehot_d;

    logic ref_load, ref_dec, ref_zero;
    logic to_load, to_dec, to_zero;

    cycle_timer #(.CNT_W(CNT_W), .RESET_VAL(REFRESH_LOAD)) u_refresh_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (ref_load),
        .load_val (REFRESH_LOAD),
        .dec      (ref_dec),
        .zero     (ref_zero)
    );

    // Loaded with TIMEOUT_CYCLES-1 in START, so it reaches zero on the last allowed WAIT cycle.
    cycle_timer #(.CNT_W(CNT_W), .RESET_VAL(TIMEOUT_LOAD)) u_timeout_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (to_load),
        .load_val (TIMEOUT_LOAD),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pending_d     = pending_q;
        timeout_err_d = timeout_err_q;
        ref_load      = 1'b0;
        ref_dec       = 1'b0;
        to_load       = 1'b0;
        to_dec        = 1'b0;

        case (state_q)
            S_IDLE: begin
                ref_dec = 1'b1;
                if (mode_btn || pending_q) begin
                    mode_d    = mode_q + 2'd1;
                    pending_d = 1'b0;
                    state_d   = S_START;
                end else if (ref_zero || force_refresh) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                to_load   = 1'b1;
                pending_d = pending_q | mode_btn;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                to_dec    = 1'b1;
                pending_d = pending_q | mode_btn;
                // The converter's valid_out is still stale on the first WAIT cycle.
                if (!first_wait_q && conv_valid) begin
                    timeout_err_d = 1'b0;
                    state_d       = S_DONE;
                end else if (to_zero) begin
                    timeout_err_d = 1'b1;
                    ref_load      = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DONE: begin
                ref_load  = 1'b1;
                pending_d = pending_q | mode_btn;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from next-state so they line up with the state they describe.
        first_wait_d = (state_q == S_START);
        start_d      = (state_d == S_START);
        busy_d       = (state_d == S_START) || (state_d == S_WAIT);
        update_d     = (state_d == S_DONE);
        onehot_d     = mode_onehot(mode_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_DAY;
            pending_q     <= 1'b0;
            first_wait_q  <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            update_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            onehot_q      <= mode_onehot(MODE_DAY);
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pending_q     <= pending_d;
            first_wait_q  <= first_wait_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            update_q      <= update_d;
            timeout_err_q <= timeout_err_d;
            onehot_q      <= onehot_d;
        end
    end

    assign start       = start_q;
    assign busy        = busy_q;
    assign update      = update_q;
    assign timeout_err = timeout_err_q;
    assign DAY         = onehot_q[0];
    assign AVS         = onehot_q[1];
    assign MAX         = onehot_q[2];
    assign TIM         = onehot_q[3];

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: a behavioural model predicts per-cycle status
// and start/update events; a monitor pops and compares them as the DUT produces outputs.
module tb_display_sequencer;

    localparam int R = 10;
    localparam int T = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mode_btn = 1'b0;
    logic force_refresh = 1'b0;
    logic conv_valid = 1'b0;
    logic start, AVS, DAY, MAX, TIM, busy, update, timeout_err;

    display_sequencer #(.REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .mode_btn      (mode_btn),
        .force_refresh (force_refresh),
        .conv_valid    (conv_valid),
        .start         (start),
        .AVS           (AVS),
        .DAY           (DAY),
        .MAX           (MAX),
        .TIM           (TIM),
        .busy          (busy),
        .update        (update),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         start;
        bit         busy;
        bit         update;
        bit         terr;
        logic [3:0] onehot;
    } status_t;

    typedef struct {
        bit         is_update;
        int         cyc;
        logic [3:0] onehot;
    } event_t;

    status_t sq[$];
    event_t  eq[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      edge_cnt = 0;
    bit      mon_en = 1'b0;

    // Reference model: m_conv = cycles since the conversion's start (-1 when not converting),
    // m_done marks the single update cycle, m_refresh counts idle cycles left.
    int m_refresh, m_conv, m_mode;
    bit m_done, m_pend, m_terr;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [3:0] onehot_of(input int mode);
        logic [3:0] v;
        v = 4'b0001 << mode;
        return v;
    endfunction

    function automatic bit m_idle();
        return (m_conv < 0) && !m_done;
    endfunction

    task automatic model_reset();
        m_refresh = R - 1;
        m_conv    = -1;
        m_mode    = 0;
        m_done    = 1'b0;
        m_pend    = 1'b0;
        m_terr    = 1'b0;
    endtask

    // Advance the model across one clock edge with the given inputs, then queue expectations.
    task automatic model_step(input bit btn, input bit frc, input bit vld);
        status_t s;
        event_t  e;
        if (m_done) begin
            m_done    = 1'b0;
            m_refresh = R - 1;
            if (btn) m_pend = 1'b1;
        end else if (m_conv >= 0) begin
            if (btn) m_pend = 1'b1;
            if (m_conv >= 2 && vld) begin
                m_conv = -1;
                m_done = 1'b1;
                m_terr = 1'b0;
                e.is_update = 1'b1;
                e.cyc       = edge_cnt + 1;
                e.onehot    = onehot_of(m_mode);
                eq.push_back(e);
            end else if (m_conv == T) begin
                m_conv    = -1;
                m_terr    = 1'b1;
                m_refresh = R - 1;
            end else begin
                m_conv++;
            end
        end else begin
            if (btn || m_pend) begin
                m_mode = (m_mode + 1) % 4;
                m_pend = 1'b0;
                m_conv = 0;
            end else if (m_refresh == 0 || frc) begin
                m_conv = 0;
            end else begin
                m_refresh--;
            end
            if (m_conv == 0) begin
                e.is_update = 1'b0;
                e.cyc       = edge_cnt + 1;
                e.onehot    = onehot_of(m_mode);
                eq.push_back(e);
            end
        end
        s.start  = (m_conv == 0);
        s.busy   = (m_conv >= 0);
        s.update = m_done;
        s.terr   = m_terr;
        s.onehot = onehot_of(m_mode);
        sq.push_back(s);
    endtask

    task automatic drive(input bit btn, input bit frc, input bit vld);
        @(negedge clock);
        mode_btn      = btn;
        force_refresh = frc;
        conv_valid    = vld;
        model_step(btn, frc, vld);
    endtask

    // Converter that answers two cycles after start.
    task automatic run_normal(input int n);
        repeat (n) drive(1'b0, 1'b0, m_conv == 2);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!m_idle() && guard < 100) begin
            drive(1'b0, 1'b0, m_conv == 2);
            guard++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"}, 32'(start), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_update"}, 32'(update), 32'(0));
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
        check({tag, "_mode"}, 32'({TIM, MAX, AVS, DAY}), 32'(4'b0001));
    endtask

    // Assert reset between edges, check outputs before the next edge, then release after one.
    task automatic async_reset(input string tag);
        @(negedge clock);
        #2;
        mon_en        = 1'b0;
        reset         = 1'b1;
        mode_btn      = 1'b0;
        force_refresh = 1'b0;
        conv_valid    = 1'b0;
        #1;
        check_reset_values(tag);
        sq.delete();
        eq.delete();
        model_reset();
        @(posedge clock);
        #3;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(posedge clock) begin : monitor
        status_t s;
        event_t  e;
        #1;
        if (mon_en) begin
            check("status_available", 32'(sq.size() != 0), 32'(1));
            if (sq.size() != 0) begin
                s = sq.pop_front();
                check("start", 32'(start), 32'(s.start));
                check("busy", 32'(busy), 32'(s.busy));
                check("update", 32'(update), 32'(s.update));
                check("timeout_err", 32'(timeout_err), 32'(s.terr));
                check("mode_onehot", 32'({TIM, MAX, AVS, DAY}), 32'(s.onehot));
                check("one_mode_high", 32'($countones({TIM, MAX, AVS, DAY})), 32'(1));
            end
            if (start || update) begin
                check("event_expected", 32'(eq.size() != 0), 32'(1));
                if (eq.size() != 0) begin
                    e = eq.pop_front();
                    check("event_kind", 32'(update), 32'(e.is_update));
                    check("event_cycle", 32'(edge_cnt), 32'(e.cyc));
                    check("event_mode", 32'({TIM, MAX, AVS, DAY}), 32'(e.onehot));
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        reset = 1'b1;
        #2;
        check_reset_values("por");
        repeat (3) @(posedge clock);
        #3;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Periodic refresh with a converter answering two cycles after start.
        run_normal(45);

        // Mode button pulses in IDLE, spaced about 20 cycles apart.
        for (int k = 0; k < 4; k++) begin
            run_normal(19);
            wait_idle();
            drive(1'b1, 1'b0, 1'b0);
        end
        run_normal(10);

        // Three presses during WAIT with a slow converter: one deferred advance.
        wait_idle();
        drive(1'b0, 1'b1, 1'b0);
        repeat (14) drive(m_conv >= 1 && m_conv <= 3, 1'b0, m_conv == 6);
        run_normal(20);

        // Stale valid held high through start.
        wait_idle();
        drive(1'b0, 1'b1, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 1'b1);
        run_normal(20);

        // Converter never answers: timeout, then a successful retry clears the error.
        wait_idle();
        drive(1'b0, 1'b1, 1'b0);
        repeat (15) drive(1'b0, 1'b0, 1'b0);
        run_normal(30);

        // Reset in START, then in WAIT.
        wait_idle();
        drive(1'b0, 1'b1, 1'b0);
        check("pre_reset_start_busy", 32'(m_conv), 32'(0));
        async_reset("rst_in_start");
        run_normal(15);
        wait_idle();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        async_reset("rst_in_wait");
        run_normal(15);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rst_random");
            end else begin
                drive($urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0,
                      $urandom_range(0, 3) == 0);
            end
        end

        @(posedge clock);
        #2;
        mon_en = 1'b0;
        check("events_drained", 32'(eq.size()), 32'(0));
        check("status_drained", 32'(sq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
